// File: rtl/pipe_controller_pkg.sv
// -----------------------------------------------------------------------------
// pipe_controller_pkg
// Shared encodings for the RV32I-subset pipeline controller:
//   - opcode constants recognised by the main decoder
//   - immediate-format, result-select, ALU-op and ALU-control encodings
//   - forwarding-mux select encodings
//   - packed control bundles carried by the E, M and W stage registers
//   - fwd_sel(): forwarding-select helper shared by the A and B operand paths
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_controller_pkg;

  // Opcodes (instr[6:0])
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // funct3 values with a dedicated ALU operation
  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } immsrc_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } resultsrc_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alucontrol_e;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,  // register file value
    FWD_W  = 2'b01,  // resultW
    FWD_M  = 2'b10   // aluresultM
  } fwd_e;

  // Execute-stage control bundle (D->E register contents)
  typedef struct packed {
    logic        regwrite;
    resultsrc_e  resultsrc;
    logic        memwrite;
    logic        jump;
    logic        branch;
    alucontrol_e alucontrol;
    logic        alusrc;
  } ctrl_e_t;

  // Memory-stage control bundle (E->M register contents)
  typedef struct packed {
    logic       regwrite;
    resultsrc_e resultsrc;
    logic       memwrite;
  } ctrl_m_t;

  // Writeback-stage control bundle (M->W register contents)
  typedef struct packed {
    logic       regwrite;
    resultsrc_e resultsrc;
  } ctrl_w_t;

  // Memory stage wins over writeback because it holds the younger result.
  // x0 is never forwarded: it always reads as zero from the register file.
  function automatic fwd_e fwd_sel(input logic [4:0] rs,
                                   input logic       regwrite_m,
                                   input logic [4:0] rd_m,
                                   input logic       regwrite_w,
                                   input logic [4:0] rd_w);
    fwd_e sel;
    sel = FWD_RF;
    if (rs != 5'd0) begin
      if (regwrite_m && (rs == rd_m)) begin
        sel = FWD_M;
      end else if (regwrite_w && (rs == rd_w)) begin
        sel = FWD_W;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipe_controller_hazard_unit.sv
// -----------------------------------------------------------------------------
// pipe_controller_hazard_unit
// Purely combinational hazard logic: operand forwarding selects for the
// execute stage, load-use stall detection, and stall/flush generation.
// Ports:
//   rs1D, rs2D   in  5  source registers of the instruction in decode
//   rs1E, rs2E   in  5  source registers of the instruction in execute
//   rdE, rdM, rdW in 5  destination registers of E, M and W stages
//   resultsrcE   in  2  result select of the instruction in execute
//   regwriteM    in  1  register write enable, memory stage
//   regwriteW    in  1  register write enable, writeback stage
//   pcsrcE       in  1  taken branch / jump resolved in execute
//   forwardAE    out 2  operand A forwarding select
//   forwardBE    out 2  operand B forwarding select
//   stallF       out 1  hold the PC
//   stallD       out 1  hold the F->D register
//   flushD       out 1  clear the F->D register
//   flushE       out 1  clear the D->E register
// -----------------------------------------------------------------------------
module pipe_controller_hazard_unit
  import pipe_controller_pkg::*;
(
  input  logic [4:0] rs1D,
  input  logic [4:0] rs2D,
  input  logic [4:0] rs1E,
  input  logic [4:0] rs2E,
  input  logic [4:0] rdE,
  input  logic [4:0] rdM,
  input  logic [4:0] rdW,
  input  logic [1:0] resultsrcE,
  input  logic       regwriteM,
  input  logic       regwriteW,
  input  logic       pcsrcE,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       stallF,
  output logic       stallD,
  output logic       flushD,
  output logic       flushE
);

  logic lw_stall;

  assign forwardAE = fwd_sel(rs1E, regwriteM, rdM, regwriteW, rdW);
  assign forwardBE = fwd_sel(rs2E, regwriteM, rdM, regwriteW, rdW);

  // A load in execute cannot forward its data until writeback, so a
  // dependent instruction in decode must wait one cycle. A load to x0
  // produces nothing to wait for.
  assign lw_stall = (resultsrcE == RES_MEM) && (rdE != 5'd0) &&
                    ((rs1D == rdE) || (rs2D == rdE));

  assign stallF = lw_stall;
  assign stallD = lw_stall;

  // When a load-use stall and a taken branch coincide, flushD discards the
  // stalled decode instruction, so the redirect takes effect.
  assign flushD = pcsrcE;
  assign flushE = lw_stall | pcsrcE;

endmodule

// File: rtl/pipe_controller.sv
// -----------------------------------------------------------------------------
// pipe_controller
// Control path for a five-stage RV32I-subset pipeline (lw, sw, R-type,
// I-type ALU, beq, jal). Decodes the instruction in D, carries its controls
// through the D->E, E->M and M->W registers, and hosts the hazard unit.
// Ports:
//   clk, rst            in  1  clock; asynchronous active-high reset
//   op                  in  7  opcode of the decode-stage instruction
//   funct3              in  3  funct3 field of the decode-stage instruction
//   funct7              in  7  funct7 field (only bit 5 is meaningful)
//   zeroE               in  1  ALU zero flag, execute stage
//   rs1D, rs2D          in  5  decode-stage source registers
//   rs1E, rs2E, rdE     in  5  execute-stage register indices
//   rdM, rdW            in  5  memory / writeback destination registers
//   immsrcD             out 2  immediate format for the decode stage
//   alucontrolE         out 3  ALU operation, execute stage
//   alusrcE             out 1  ALU B operand select (1 = immediate)
//   pcsrcE              out 1  redirect the PC (taken beq or jal)
//   memwriteM           out 1  data memory write strobe
//   resultsrcW          out 2  writeback result select
//   regwriteW           out 1  register file write enable
//   forwardAE/BE        out 2  execute operand forwarding selects
//   stallF, stallD      out 1  load-use stall
//   flushD, flushE      out 1  pipeline register clears
// -----------------------------------------------------------------------------
module pipe_controller
  import pipe_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zeroE,
  input  logic [4:0] rs1D,
  input  logic [4:0] rs2D,
  input  logic [4:0] rs1E,
  input  logic [4:0] rs2E,
  input  logic [4:0] rdE,
  input  logic [4:0] rdM,
  input  logic [4:0] rdW,
  output logic [1:0] immsrcD,
  output logic [2:0] alucontrolE,
  output logic       alusrcE,
  output logic       pcsrcE,
  output logic       memwriteM,
  output logic [1:0] resultsrcW,
  output logic       regwriteW,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       stallF,
  output logic       stallD,
  output logic       flushD,
  output logic       flushE
);

  // ---------------------------------------------------------------------------
  // Main decoder (D stage)
  // ---------------------------------------------------------------------------
  logic        dec_regwrite;
  immsrc_e     dec_immsrc;
  logic        dec_alusrc;
  logic        dec_memwrite;
  resultsrc_e  dec_resultsrc;
  logic        dec_branch;
  aluop_e      dec_aluop;
  logic        dec_jump;
  alucontrol_e dec_alucontrol;
  logic        is_rtype;

  // Only funct7[5] distinguishes add from sub; the rest is don't-care here.
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_comb begin
    // Unknown opcodes fall through with everything inactive.
    dec_regwrite  = 1'b0;
    dec_immsrc    = IMM_I;
    dec_alusrc    = 1'b0;
    dec_memwrite  = 1'b0;
    dec_resultsrc = RES_ALU;
    dec_branch    = 1'b0;
    dec_aluop     = ALUOP_ADD;
    dec_jump      = 1'b0;
    case (op)
      OP_LW: begin
        dec_regwrite  = 1'b1;
        dec_immsrc    = IMM_I;
        dec_alusrc    = 1'b1;
        dec_resultsrc = RES_MEM;
      end
      OP_SW: begin
        dec_immsrc   = IMM_S;
        dec_alusrc   = 1'b1;
        dec_memwrite = 1'b1;
      end
      OP_R: begin
        dec_regwrite = 1'b1;
        dec_aluop    = ALUOP_FUNCT;
      end
      OP_I: begin
        dec_regwrite = 1'b1;
        dec_immsrc   = IMM_I;
        dec_alusrc   = 1'b1;
        dec_aluop    = ALUOP_FUNCT;
      end
      OP_BEQ: begin
        dec_immsrc = IMM_B;
        dec_branch = 1'b1;
        dec_aluop  = ALUOP_SUB;
      end
      OP_JAL: begin
        dec_regwrite  = 1'b1;
        dec_immsrc    = IMM_J;
        dec_resultsrc = RES_PC4;
        dec_jump      = 1'b1;
      end
      default: ;
    endcase
  end

  assign immsrcD = dec_immsrc;

  // ---------------------------------------------------------------------------
  // ALU decoder (D stage)
  // ---------------------------------------------------------------------------
  assign is_rtype = (op == OP_R);

  always_comb begin
    dec_alucontrol = ALU_ADD;
    case (dec_aluop)
      ALUOP_ADD: dec_alucontrol = ALU_ADD;
      ALUOP_SUB: dec_alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // funct7[5] in an I-type is an immediate bit, so addi never subtracts.
          F3_ADDSUB: dec_alucontrol = (is_rtype && funct7[5]) ? ALU_SUB : ALU_ADD;
          F3_SLT:    dec_alucontrol = ALU_SLT;
          F3_OR:     dec_alucontrol = ALU_OR;
          F3_AND:    dec_alucontrol = ALU_AND;
          default:   dec_alucontrol = ALU_ADD;
        endcase
      end
      default: dec_alucontrol = ALU_ADD;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control pipeline registers
  // ---------------------------------------------------------------------------
  ctrl_e_t ctrl_e_d, ctrl_e_q;
  ctrl_m_t ctrl_m_d, ctrl_m_q;
  ctrl_w_t ctrl_w_d, ctrl_w_q;

  always_comb begin
    ctrl_e_d.regwrite   = dec_regwrite;
    ctrl_e_d.resultsrc  = dec_resultsrc;
    ctrl_e_d.memwrite   = dec_memwrite;
    ctrl_e_d.jump       = dec_jump;
    ctrl_e_d.branch     = dec_branch;
    ctrl_e_d.alucontrol = dec_alucontrol;
    ctrl_e_d.alusrc     = dec_alusrc;
    // A flushed slot enters execute as a bubble that writes nothing.
    if (flushE) begin
      ctrl_e_d = '0;
    end
  end

  always_comb begin
    ctrl_m_d.regwrite  = ctrl_e_q.regwrite;
    ctrl_m_d.resultsrc = ctrl_e_q.resultsrc;
    ctrl_m_d.memwrite  = ctrl_e_q.memwrite;
  end

  always_comb begin
    ctrl_w_d.regwrite  = ctrl_m_q.regwrite;
    ctrl_w_d.resultsrc = ctrl_m_q.resultsrc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_e_q <= '0;
      ctrl_m_q <= '0;
      ctrl_w_q <= '0;
    end else begin
      ctrl_e_q <= ctrl_e_d;
      ctrl_m_q <= ctrl_m_d;
      ctrl_w_q <= ctrl_w_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage outputs
  // ---------------------------------------------------------------------------
  assign alucontrolE = ctrl_e_q.alucontrol;
  assign alusrcE     = ctrl_e_q.alusrc;
  assign pcsrcE      = (ctrl_e_q.branch & zeroE) | ctrl_e_q.jump;
  assign memwriteM   = ctrl_m_q.memwrite;
  assign resultsrcW  = ctrl_w_q.resultsrc;
  assign regwriteW   = ctrl_w_q.regwrite;

  // ---------------------------------------------------------------------------
  // Hazard unit
  // ---------------------------------------------------------------------------
  pipe_controller_hazard_unit hazard_unit (
    .rs1D       (rs1D),
    .rs2D       (rs2D),
    .rs1E       (rs1E),
    .rs2E       (rs2E),
    .rdE        (rdE),
    .rdM        (rdM),
    .rdW        (rdW),
    .resultsrcE (ctrl_e_q.resultsrc),
    .regwriteM  (ctrl_m_q.regwrite),
    .regwriteW  (ctrl_w_q.regwrite),
    .pcsrcE     (pcsrcE),
    .forwardAE  (forwardAE),
    .forwardBE  (forwardBE),
    .stallF     (stallF),
    .stallD     (stallD),
    .flushD     (flushD),
    .flushE     (flushE)
  );

endmodule

// File: tb/tb_pipe_controller.sv
// -----------------------------------------------------------------------------
// tb_pipe_controller
// Directed instruction sequences drive the controller one decode slot per
// cycle. The driver pushes hand-computed expected output values into a queue;
// a monitor pops and compares them at each falling clock edge (and on an extra
// sample point inside the asynchronous reset pulse).
// -----------------------------------------------------------------------------
module tb_pipe_controller;

  // Opcodes
  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IT   = 7'b0010011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] ILL  = 7'b1111111;
  localparam logic [6:0] NOP  = 7'b0000000;
  localparam logic [6:0] F7_0 = 7'b0000000;
  localparam logic [6:0] F7_S = 7'b0100000;

  // Observed signal ids
  localparam int S_IMM   = 0;
  localparam int S_ALUC  = 1;
  localparam int S_ALUS  = 2;
  localparam int S_PCSRC = 3;
  localparam int S_MEMW  = 4;
  localparam int S_RES   = 5;
  localparam int S_REGW  = 6;
  localparam int S_FA    = 7;
  localparam int S_FB    = 8;
  localparam int S_STF   = 9;
  localparam int S_STD   = 10;
  localparam int S_FLD   = 11;
  localparam int S_FLE   = 12;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zeroE;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic [4:0] rd_d;
  logic [1:0] immsrcD;
  logic [2:0] alucontrolE;
  logic       alusrcE, pcsrcE, memwriteM, regwriteW;
  logic [1:0] resultsrcW, forwardAE, forwardBE;
  logic       stallF, stallD, flushD, flushE;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  pipe_controller dut (
    .clk         (clk),
    .rst         (rst),
    .op          (op),
    .funct3      (funct3),
    .funct7      (funct7),
    .zeroE       (zeroE),
    .rs1D        (rs1D),
    .rs2D        (rs2D),
    .rs1E        (rs1E),
    .rs2E        (rs2E),
    .rdE         (rdE),
    .rdM         (rdM),
    .rdW         (rdW),
    .immsrcD     (immsrcD),
    .alucontrolE (alucontrolE),
    .alusrcE     (alusrcE),
    .pcsrcE      (pcsrcE),
    .memwriteM   (memwriteM),
    .resultsrcW  (resultsrcW),
    .regwriteW   (regwriteW),
    .forwardAE   (forwardAE),
    .forwardBE   (forwardBE),
    .stallF      (stallF),
    .stallD      (stallD),
    .flushD      (flushD),
    .flushE      (flushE)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [2:0] exp_q[$];
  int         sig_q[$];
  string      name_q[$];
  int         tests_run;
  int         fail_count;
  event       mon_ev;

  always @(negedge clk) -> mon_ev;

  function automatic logic [2:0] observe(input int s);
    case (s)
      S_IMM:   return {1'b0, immsrcD};
      S_ALUC:  return alucontrolE;
      S_ALUS:  return {2'b0, alusrcE};
      S_PCSRC: return {2'b0, pcsrcE};
      S_MEMW:  return {2'b0, memwriteM};
      S_RES:   return {1'b0, resultsrcW};
      S_REGW:  return {2'b0, regwriteW};
      S_FA:    return {1'b0, forwardAE};
      S_FB:    return {1'b0, forwardBE};
      S_STF:   return {2'b0, stallF};
      S_STD:   return {2'b0, stallD};
      S_FLD:   return {2'b0, flushD};
      S_FLE:   return {2'b0, flushE};
      default: return 3'bxxx;
    endcase
  endfunction

  initial begin : monitor
    logic [2:0] e;
    logic [2:0] a;
    int         s;
    string      n;
    forever begin
      @(mon_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        s = sig_q.pop_front();
        n = name_q.pop_front();
        a = observe(s);
        tests_run++;
        if (a !== e) begin
          fail_count++;
          $display("FAIL %s: got %0d expected %0d (t=%0t)", n, a, e, $time);
        end
      end
    end
  end

  task automatic expect_sig(input string name, input int sig, input logic [2:0] val);
    exp_q.push_back(val);
    sig_q.push_back(sig);
    name_q.push_back(name);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Advance one cycle and present a new decode instruction. The register
  // indices move down the stages the way the datapath would carry them;
  // bub marks that the slot entering execute was flushed.
  task automatic issue(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                       input logic z, input logic bub);
    @(posedge clk);
    #1;
    rdW = rdM;
    rdM = rdE;
    if (bub) begin
      rs1E = 5'd0; rs2E = 5'd0; rdE = 5'd0;
    end else begin
      rs1E = rs1D; rs2E = rs2D; rdE = rd_d;
    end
    op = o; funct3 = f3; funct7 = f7;
    rs1D = s1; rs2D = s2; rd_d = d;
    zeroE = z;
  endtask

  task automatic nop(input logic z, input logic bub);
    issue(NOP, 3'b000, F7_0, 5'd0, 5'd0, 5'd0, z, bub);
  endtask

  task automatic clear_indices();
    rs1D = 5'd0; rs2D = 5'd0; rd_d = 5'd0;
    rs1E = 5'd0; rs2E = 5'd0; rdE = 5'd0;
    rdM = 5'd0; rdW = 5'd0;
  endtask

  // Reset pulse placed between a falling and the next rising edge, sampled
  // while still asserted so no clock edge can mask a missing async clear.
  task automatic pulse_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    expect_sig("rst_async_regwriteW",   S_REGW,  3'd0);
    expect_sig("rst_async_resultsrcW",  S_RES,   3'd0);
    expect_sig("rst_async_memwriteM",   S_MEMW,  3'd0);
    expect_sig("rst_async_alucontrolE", S_ALUC,  3'd0);
    expect_sig("rst_async_pcsrcE",      S_PCSRC, 3'd0);
    -> mon_ev;
    #1;
    rst = 1'b0;
    clear_indices();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : driver
    tests_run  = 0;
    fail_count = 0;
    rst = 1'b1;
    op = NOP; funct3 = 3'b000; funct7 = F7_0; zeroE = 1'b0;
    clear_indices();

    #1;
    expect_sig("reset_regwriteW",   S_REGW,  3'd0);
    expect_sig("reset_memwriteM",   S_MEMW,  3'd0);
    expect_sig("reset_resultsrcW",  S_RES,   3'd0);
    expect_sig("reset_alucontrolE", S_ALUC,  3'd0);
    expect_sig("reset_alusrcE",     S_ALUS,  3'd0);
    expect_sig("reset_pcsrcE",      S_PCSRC, 3'd0);
    expect_sig("reset_forwardAE",   S_FA,    3'd0);
    expect_sig("reset_forwardBE",   S_FB,    3'd0);
    @(negedge clk);
    #2;
    rst = 1'b0;

    // Forwarding: back-to-back, one gap, x0 producer
    issue(RT, 3'b000, F7_0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);   // add x3,x1,x2
    issue(RT, 3'b000, F7_S, 5'd3, 5'd1, 5'd4, 1'b0, 1'b0);   // sub x4,x3,x1
    expect_sig("add_alucontrolE", S_ALUC, 3'b000);
    expect_sig("add_alusrcE",     S_ALUS, 3'd0);
    nop(1'b0, 1'b0);
    expect_sig("b2b_forwardAE",   S_FA,   3'b010);
    expect_sig("b2b_forwardBE",   S_FB,   3'b000);
    expect_sig("sub_alucontrolE", S_ALUC, 3'b001);
    issue(RT, 3'b000, F7_0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);   // add x3,x1,x2
    nop(1'b0, 1'b0);
    issue(RT, 3'b000, F7_S, 5'd3, 5'd1, 5'd4, 1'b0, 1'b0);   // sub x4,x3,x1
    nop(1'b0, 1'b0);
    expect_sig("gap_forwardAE", S_FA,   3'b001);
    expect_sig("gap_regwriteW", S_REGW, 3'd1);
    issue(RT, 3'b000, F7_0, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);   // add x0,x1,x2
    issue(RT, 3'b000, F7_S, 5'd0, 5'd1, 5'd4, 1'b0, 1'b0);   // sub x4,x0,x1
    nop(1'b0, 1'b0);
    expect_sig("x0_forwardAE", S_FA, 3'b000);
    expect_sig("x0_forwardBE", S_FB, 3'b000);

    // Load-use stall
    issue(LW, 3'b010, F7_0, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0);   // lw x5,0(x0)
    expect_sig("lw_immsrcD", S_IMM, 3'b000);
    issue(RT, 3'b000, F7_0, 5'd5, 5'd5, 5'd6, 1'b0, 1'b0);   // add x6,x5,x5
    expect_sig("lu_stallF",      S_STF,  3'd1);
    expect_sig("lu_stallD",      S_STD,  3'd1);
    expect_sig("lu_flushE",      S_FLE,  3'd1);
    expect_sig("lu_flushD",      S_FLD,  3'd0);
    expect_sig("lw_alusrcE",     S_ALUS, 3'd1);
    issue(RT, 3'b000, F7_0, 5'd5, 5'd5, 5'd6, 1'b0, 1'b1);   // held in decode
    expect_sig("lu_release_stallF", S_STF, 3'd0);
    expect_sig("lu_release_flushE", S_FLE, 3'd0);
    nop(1'b0, 1'b0);
    expect_sig("lu_forwardAE",   S_FA,   3'b001);
    expect_sig("lu_forwardBE",   S_FB,   3'b001);
    expect_sig("lw_resultsrcW",  S_RES,  3'b001);
    expect_sig("lw_regwriteW",   S_REGW, 3'd1);
    nop(1'b0, 1'b0);
    expect_sig("bubble_regwriteW", S_REGW, 3'd0);

    // Branch taken / not taken, jal
    issue(BEQ, 3'b000, F7_0, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
    expect_sig("beq_immsrcD", S_IMM, 3'b010);
    nop(1'b1, 1'b0);
    expect_sig("beq_t_pcsrcE",      S_PCSRC, 3'd1);
    expect_sig("beq_t_flushD",      S_FLD,   3'd1);
    expect_sig("beq_t_flushE",      S_FLE,   3'd1);
    expect_sig("beq_t_stallF",      S_STF,   3'd0);
    expect_sig("beq_alucontrolE",   S_ALUC,  3'b001);
    issue(BEQ, 3'b000, F7_0, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1);
    nop(1'b0, 1'b0);
    expect_sig("beq_nt_pcsrcE", S_PCSRC, 3'd0);
    expect_sig("beq_nt_flushD", S_FLD,   3'd0);
    expect_sig("beq_nt_flushE", S_FLE,   3'd0);
    issue(JAL, 3'b000, F7_0, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0);  // jal x1
    expect_sig("jal_immsrcD", S_IMM, 3'b011);
    nop(1'b0, 1'b0);
    expect_sig("jal_pcsrcE",  S_PCSRC, 3'd1);
    expect_sig("jal_flushD",  S_FLD,   3'd1);
    expect_sig("jal_flushE",  S_FLE,   3'd1);
    expect_sig("jal_alusrcE", S_ALUS,  3'd0);
    nop(1'b0, 1'b1);
    expect_sig("jal_bubble_pcsrcE", S_PCSRC, 3'd0);
    nop(1'b0, 1'b0);
    expect_sig("jal_resultsrcW", S_RES,  3'b010);
    expect_sig("jal_regwriteW",  S_REGW, 3'd1);

    // Store
    issue(SW, 3'b010, F7_0, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);   // sw x2,4(x1)
    expect_sig("sw_immsrcD", S_IMM, 3'b001);
    nop(1'b0, 1'b0);
    expect_sig("sw_alusrcE",     S_ALUS, 3'd1);
    expect_sig("sw_alucontrolE", S_ALUC, 3'b000);
    expect_sig("sw_E_memwriteM", S_MEMW, 3'd0);
    nop(1'b0, 1'b0);
    expect_sig("sw_memwriteM",   S_MEMW, 3'd1);
    nop(1'b0, 1'b0);
    expect_sig("sw_W_memwriteM", S_MEMW, 3'd0);
    expect_sig("sw_regwriteW",   S_REGW, 3'd0);

    // ALU decode corners and illegal opcode
    issue(IT, 3'b000, F7_S, 5'd1, 5'd0, 5'd7, 1'b0, 1'b0);   // addi, imm bit 10 set
    issue(IT, 3'b010, F7_0, 5'd1, 5'd0, 5'd7, 1'b0, 1'b0);   // slti
    expect_sig("addi_alucontrolE", S_ALUC, 3'b000);
    expect_sig("addi_alusrcE",     S_ALUS, 3'd1);
    issue(RT, 3'b110, F7_0, 5'd1, 5'd2, 5'd7, 1'b0, 1'b0);   // or
    expect_sig("slti_alucontrolE", S_ALUC, 3'b101);
    issue(RT, 3'b111, F7_0, 5'd1, 5'd2, 5'd7, 1'b0, 1'b0);   // and
    expect_sig("or_alucontrolE", S_ALUC, 3'b011);
    expect_sig("or_alusrcE",     S_ALUS, 3'd0);
    issue(RT, 3'b001, F7_0, 5'd1, 5'd2, 5'd7, 1'b0, 1'b0);   // sll (unsupported)
    expect_sig("and_alucontrolE", S_ALUC, 3'b010);
    issue(ILL, 3'b111, F7_S, 5'd1, 5'd2, 5'd7, 1'b0, 1'b0);
    expect_sig("sll_alucontrolE", S_ALUC, 3'b000);
    expect_sig("ill_immsrcD",     S_IMM,  3'b000);
    nop(1'b1, 1'b0);
    expect_sig("ill_alucontrolE", S_ALUC,  3'b000);
    expect_sig("ill_alusrcE",     S_ALUS,  3'd0);
    expect_sig("ill_pcsrcE",      S_PCSRC, 3'd0);
    nop(1'b0, 1'b0);
    expect_sig("ill_memwriteM", S_MEMW, 3'd0);
    nop(1'b0, 1'b0);
    expect_sig("ill_regwriteW",  S_REGW, 3'd0);
    expect_sig("ill_resultsrcW", S_RES,  3'b000);

    // Reset while in flight: lw x9 in W, lw x5 in M, sub in E
    issue(LW, 3'b010, F7_0, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0);
    issue(LW, 3'b010, F7_0, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0);
    expect_sig("lw9_no_stall", S_STF, 3'd0);
    issue(RT, 3'b000, F7_S, 5'd1, 5'd2, 5'd6, 1'b0, 1'b0);
    expect_sig("lw5_no_stall", S_STF, 3'd0);
    nop(1'b0, 1'b0);
    expect_sig("pre_rst_regwriteW",   S_REGW, 3'd1);
    expect_sig("pre_rst_resultsrcW",  S_RES,  3'b001);
    expect_sig("pre_rst_alucontrolE", S_ALUC, 3'b001);
    expect_sig("pre_rst_memwriteM",   S_MEMW, 3'd0);
    pulse_reset();
    issue(IT, 3'b000, F7_0, 5'd1, 5'd0, 5'd7, 1'b0, 1'b0);   // addi x7
    expect_sig("post_rst_regwriteW_0", S_REGW, 3'd0);
    nop(1'b0, 1'b0);
    expect_sig("post_rst_regwriteW_1", S_REGW, 3'd0);
    expect_sig("post_rst_alusrcE",     S_ALUS, 3'd1);
    nop(1'b0, 1'b0);
    nop(1'b0, 1'b0);
    expect_sig("post_rst_addi_regwriteW",  S_REGW, 3'd1);
    expect_sig("post_rst_addi_resultsrcW", S_RES,  3'b000);

    // M-over-W forwarding priority
    issue(RT, 3'b000, F7_0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
    issue(RT, 3'b000, F7_0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
    issue(RT, 3'b000, F7_0, 5'd3, 5'd3, 5'd4, 1'b0, 1'b0);
    nop(1'b0, 1'b0);
    expect_sig("prio_forwardAE", S_FA, 3'b010);
    expect_sig("prio_forwardBE", S_FB, 3'b010);

    // Load to x0 never stalls; rs2-only dependence does
    issue(LW, 3'b010, F7_0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    issue(RT, 3'b000, F7_0, 5'd0, 5'd0, 5'd6, 1'b0, 1'b0);
    expect_sig("lwx0_stallF", S_STF, 3'd0);
    expect_sig("lwx0_flushE", S_FLE, 3'd0);
    issue(LW, 3'b010, F7_0, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0);
    issue(RT, 3'b000, F7_0, 5'd1, 5'd5, 5'd6, 1'b0, 1'b0);
    expect_sig("rs2_stallD", S_STD, 3'd1);
    expect_sig("rs2_flushE", S_FLE, 3'd1);
    issue(RT, 3'b000, F7_0, 5'd1, 5'd5, 5'd6, 1'b0, 1'b1);
    expect_sig("rs2_release_stallD", S_STD, 3'd0);

    nop(1'b0, 1'b0);
    @(negedge clk);
    #1;
    tests_run++;
    if (exp_q.size() != 0) begin
      fail_count++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipe_controller.md
PIPE_CONTROLLER -- requirements
Module: pipe_controller

Interface
REQ-001 Parameters: none; all widths fixed for RV32I subset.
REQ-002 clk  in  1  sole clock; all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 op  in  7  opcode of instrD; funct3 in 3, funct7 in 7 (bit 5 used).
REQ-005 zeroE  in  1  ALU zero flag, execute stage.
REQ-006 rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW  in  5 each  register indices per stage.
REQ-007 immsrcD  out  2  immediate format: 00 I, 01 S, 10 B, 11 J.
REQ-008 alucontrolE  out  3; alusrcE  out  1; pcsrcE  out  1  execute-stage controls.
REQ-009 memwriteM  out  1  data memory write strobe.
REQ-010 resultsrcW  out  2  writeback select: 00 ALU, 01 memory, 10 pc+4; regwriteW  out  1.
REQ-011 forwardAE, forwardBE  out  2  00 regfile, 01 resultW, 10 aluresultM.
REQ-012 stallF, stallD, flushD, flushE  out  1 each  hazard controls.

Function
REQ-013 Decode (combinational, D stage): lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, beq 1100011, jal 1101111; any other opcode SHALL produce all-zero controls (no write, no branch, no jump).
REQ-014 Per opcode {regwrite,immsrc,alusrc,memwrite,resultsrc,branch,aluop,jump}: lw 1,00,1,0,01,0,00,0; sw 0,01,1,1,00,0,00,0; R 1,xx,0,0,00,0,10,0; I 1,00,1,0,00,0,10,0; beq 0,10,0,0,00,1,01,0; jal 1,11,x,0,10,0,00,1 (x driven 0).
REQ-015 ALU decode: aluop 00 -> 000 add; 01 -> 001 sub; 10 by funct3: 000 -> sub (001) only if R-type and funct7[5]=1, else add; 010 -> 101 slt; 110 -> 011 or; 111 -> 010 and; other funct3 -> 000.
REQ-016 D->E control register {regwrite,resultsrc,memwrite,jump,branch,alucontrol,alusrc}; flushE SHALL load all zeros on that edge.
REQ-017 E->M register {regwrite,resultsrc,memwrite}; M->W register {regwrite,resultsrc}; no enable, no clear.
REQ-018 pcsrcE = (branchE & zeroE) | jumpE, combinational.
REQ-019 forwardAE = 10 if regwriteM & rs1E==rdM & rs1E!=0; else 01 if regwriteW & rs1E==rdW & rs1E!=0; else 00. M priority over W when both match. forwardBE identical with rs2E.
REQ-020 lwStall = (resultsrcE==01) & rdE!=0 & (rs1D==rdE | rs2D==rdE).
REQ-021 stallF = stallD = lwStall; flushD = pcsrcE; flushE = lwStall | pcsrcE.
REQ-022 Simultaneous lwStall and pcsrcE: both flushes and stalls asserted; branch wins since flushD clears the stalled decode instruction.
REQ-023 Latency: decoded control reaches E 1 cycle, M 2 cycles, W 3 cycles after D; a flushed slot propagates as a bubble (no write anywhere).
REQ-024 Hazard outputs purely combinational from current stage registers and inputs; no extra cycle.

Reset
REQ-025 rst asserted: all D->E, E->M, M->W control registers clear to 0 immediately, regardless of clk.
REQ-026 During/after reset: regwriteW=0, memwriteM=0, resultsrcW=00, alucontrolE=000, alusrcE=0, pcsrcE=0, forward*=00 unless indices match with regwrite set (cannot occur from reset).
REQ-027 Reset mid-operation SHALL discard all in-flight control; first decoded instruction after release propagates normally.

Structure
REQ-028 Shared package: opcode constants, immsrc, resultsrc, aluop and alucontrol encodings, forward select encodings.
REQ-029 One sub-module hazard_unit: forwarding, lwStall, stall/flush outputs (REQ-019..022); decoders and control pipeline registers in pipe_controller.

Verification
REQ-030 R-type add x3,x1,x2 then sub x4,x3,x1 back-to-back -> second in E: forwardAE=10; one gap -> forwardAE=01; rd=x0 producer -> forwardAE=00.
REQ-031 lw x5,0(x0) then add x6,x5,x5 -> one cycle stallF=stallD=flushE=1; next cycle forwardAE=forwardBE=01; regwriteW for the bubble=0.
REQ-032 beq with zeroE=1 -> pcsrcE=1, flushD=1, flushE=1 same cycle; zeroE=0 -> all 0; jal -> pcsrcE=1 independent of zeroE, resultsrcW=10 three cycles later.
REQ-033 sw in D -> immsrcD=01, memwriteM=1 exactly two cycles later, regwriteW=0.
REQ-034 Illegal op 1111111 -> regwriteW, memwriteM, pcsrcE all 0 through pipeline.
REQ-035 rst pulsed while lw in M and R-type in E -> memwriteM, regwriteW, resultsrcW zero immediately, before next clk edge.
